// File: rtl/lzc_denorm.sv
// lzc_denorm: rebuilds an operand from its normalized form and leading-zero
// count (o_data = i_norm >> i_cnt). Two-stage pipelined barrel right shifter
// with valid/ready handshakes on both sides and malformed-input flagging.
//
// Ports:
//   clk      clock, all state on rising edge
//   rstn     synchronous active-low reset
//   i_norm   normalized data (MSB set unless the count encodes all-zeroes)
//   i_cnt    lzc count: 0..WIDTH-1 = shift, WIDTH = all-zeroes, above = invalid
//   i_valid  input beat valid
//   i_ready  block can accept an input beat this cycle
//   o_data   denormalized data
//   o_err    beat carried a malformed count/data pair
//   o_valid  output beat valid
//   o_ready  downstream accepts the output beat
module lzc_denorm #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [WIDTH-1:0]       i_norm,
  input  logic [$clog2(WIDTH):0] i_cnt,
  input  logic                   i_valid,
  output logic                   i_ready,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_err,
  output logic                   o_valid,
  input  logic                   o_ready
);

  localparam int SB = $clog2(WIDTH);
  localparam int LO = SB / 2;

  logic             adv1;
  logic             adv2;
  logic [SB-1:0]    coarse_amt;
  logic             cnt_in_range;
  logic             cnt_all_zero;

  logic             s1_valid_d, s1_valid_q;
  logic [WIDTH-1:0] s1_tmp_d,   s1_tmp_q;
  logic [LO-1:0]    s1_fine_d,  s1_fine_q;
  logic             s1_err_d,   s1_err_q;

  logic             s2_valid_d, s2_valid_q;
  logic [WIDTH-1:0] o_data_d,   o_data_q;
  logic             o_err_d,    o_err_q;

  // A stage advances when its successor can take its contents this cycle.
  always_comb begin
    adv2 = ~s2_valid_q | o_ready;
    adv1 = ~s1_valid_q | adv2;
  end

  // Stage 1: coarse shift by the upper count bits, plus classification.
  always_comb begin
    coarse_amt   = {i_cnt[SB-1:LO], {LO{1'b0}}};
    cnt_in_range = ~i_cnt[SB];
    cnt_all_zero = i_cnt[SB] & ~|i_cnt[SB-1:0];

    s1_valid_d = s1_valid_q;
    s1_tmp_d   = s1_tmp_q;
    s1_fine_d  = s1_fine_q;
    s1_err_d   = s1_err_q;

    if (adv1) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_fine_d = i_cnt[LO-1:0];
        if (cnt_in_range) begin
          s1_tmp_d = i_norm >> coarse_amt;
          s1_err_d = ~i_norm[WIDTH-1];
        end else begin
          // All-zeroes code and unused codes both produce zero; zeroing tmp
          // here makes the fine shift in stage 2 irrelevant.
          s1_tmp_d = '0;
          s1_err_d = cnt_all_zero ? |i_norm : 1'b1;
        end
      end
    end
  end

  // Stage 2: fine shift by the low count bits into the output register.
  always_comb begin
    s2_valid_d = s2_valid_q;
    o_data_d   = o_data_q;
    o_err_d    = o_err_q;

    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        o_data_d = s1_tmp_q >> s1_fine_q;
        o_err_d  = s1_err_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_tmp_q   <= '0;
      s1_fine_q  <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      o_data_q   <= '0;
      o_err_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tmp_q   <= s1_tmp_d;
      s1_fine_q  <= s1_fine_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      o_data_q   <= o_data_d;
      o_err_q    <= o_err_d;
    end
  end

  assign i_ready = adv1;
  assign o_valid = s2_valid_q;
  assign o_data  = o_data_q;
  assign o_err   = o_err_q;

endmodule

// File: tb/tb_lzc_denorm.sv
// Testbench for lzc_denorm (WIDTH=16). Expected results are pushed to a
// scoreboard queue when an input beat is accepted and compared when the
// matching output beat is transferred.
module tb_lzc_denorm;

  localparam int W = 16;

  logic          clk;
  logic          rstn;
  logic [W-1:0]  i_norm;
  logic [4:0]    i_cnt;
  logic          i_valid;
  logic          i_ready;
  logic [W-1:0]  o_data;
  logic          o_err;
  logic          o_valid;
  logic          o_ready;

  int            tests_run;
  int            tests_failed;
  logic [W:0]    sb_q[$];
  logic [W:0]    drv_exp;
  logic          last_acc;

  lzc_denorm #(.WIDTH(W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_norm  (i_norm),
    .i_cnt   (i_cnt),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_err   (o_err),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {err, data}
  function automatic logic [W:0] model(input logic [W-1:0] n, input logic [4:0] c);
    if (c < 5'd16)       return {~n[W-1], n >> c};
    else if (c == 5'd16) return {(n != '0), {W{1'b0}}};
    else                 return {1'b1, {W{1'b0}}};
  endfunction

  // Advance one cycle. At the falling edge the handshakes that will fire on the
  // next rising edge are observed: outputs are checked, accepted inputs queued.
  task automatic tick();
    logic [W:0] e;
    @(negedge clk);
    last_acc = 1'b0;
    if (rstn) begin
      if (o_valid && o_ready) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected: got err=%0b data=%h, required no output", o_err, o_data);
        end else begin
          e = sb_q.pop_front();
          if ({o_err, o_data} !== e) begin
            tests_failed++;
            $display("FAIL sb_beat: got err=%0b data=%h, required err=%0b data=%h",
                     o_err, o_data, e[W], e[W-1:0]);
          end
        end
      end
      if (i_valid && i_ready) begin
        sb_q.push_back(drv_exp);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] n, input logic [4:0] c);
    i_norm  = n;
    i_cnt   = c;
    i_valid = 1'b1;
    drv_exp = model(n, c);
  endtask

  task automatic send(input logic [W-1:0] n, input logic [4:0] c, input string name);
    int guard;
    drive(n, c);
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!last_acc && guard < 50);
    if (!last_acc) begin
      tests_failed++;
      $display("FAIL %s_accept: got no accept in 50 cycles, required accept", name);
    end
  endtask

  task automatic drain(input string name);
    int guard;
    i_valid = 1'b0;
    o_ready = 1'b1;
    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn    = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({o_valid, o_err, o_data, i_ready} !== {1'b0, 1'b0, 16'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%0b err=%0b data=%h rdy=%0b, required 0 0 0000 1",
               o_valid, o_err, o_data, i_ready);
    end
    rstn = 1'b1;
  endtask

  task automatic test_back_to_back();
    o_ready = 1'b1;
    drive(16'h8000, 5'd0);
    tick();
    tests_run++;
    if (o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_early: got o_valid=%0b, required 0", o_valid);
    end
    drive(16'h8000, 5'd15);
    tick();
    tests_run++;
    if (o_valid !== 1'b1 || o_data !== 16'h8000 || o_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first: got v=%0b d=%h e=%0b, required 1 8000 0", o_valid, o_data, o_err);
    end
    i_valid = 1'b0;
    tick();
    tests_run++;
    if (o_valid !== 1'b1 || o_data !== 16'h0001 || o_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second: got v=%0b d=%h e=%0b, required 1 0001 0", o_valid, o_data, o_err);
    end
    tick();
    tests_run++;
    if (o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: got o_valid=%0b, required 0", o_valid);
    end
    drain("b2b");
  endtask

  task automatic test_classify();
    logic [W-1:0] vn[8] = '{16'hB400, 16'h0000, 16'h4000, 16'h0001,
                            16'h8000, 16'hFFFF, 16'hF000, 16'h0000};
    logic [4:0]   vc[8] = '{5'd5, 5'd16, 5'd3, 5'd16, 5'd17, 5'd31, 5'd12, 5'd7};
    o_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(vn[k], vc[k], "classify");
    drain("classify");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] bn[3] = '{16'h8000, 16'hC000, 16'h9000};
    logic [4:0]   bc[3] = '{5'd1, 5'd2, 5'd4};
    int           k;
    logic         have;
    logic [W-1:0] held;
    o_ready = 1'b0;
    k = 0;
    have = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive(bn[k], bc[k]);
      tick();
      if (last_acc) k++;
      if (o_valid) begin
        if (!have) begin
          have = 1'b1;
          held = o_data;
        end else begin
          tests_run++;
          if (o_data !== held) begin
            tests_failed++;
            $display("FAIL bp_hold: got %h, required %h", o_data, held);
          end
        end
      end
    end
    tests_run++;
    if (k != 2 || i_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 16'h4000) begin
      tests_failed++;
      $display("FAIL bp_stall: got acc=%0d rdy=%0b v=%0b d=%h, required 2 0 1 4000",
               k, i_ready, o_valid, o_data);
    end
    o_ready = 1'b1;
    send(bn[2], bc[2], "bp");
    drain("bp");
  endtask

  task automatic test_reset_flush();
    o_ready = 1'b0;
    send(16'h4000, 5'd3, "flush");
    send(16'h8000, 5'd0, "flush");
    i_valid = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    tests_run++;
    if (o_valid !== 1'b0 || o_data !== 16'h0 || o_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_reset: got v=%0b d=%h e=%0b, required 0 0000 0", o_valid, o_data, o_err);
    end
    sb_q.delete();
    rstn = 1'b1;
    o_ready = 1'b1;
    repeat (4) begin
      tick();
      tests_run++;
      if (o_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL flush_ghost: got o_valid=%0b, required 0", o_valid);
      end
    end
  endtask

  task automatic test_round_trip();
    logic [W-1:0] x;
    logic [4:0]   c;
    int           guard;
    for (int i = 0; i < 1000; i++) begin
      if (i % 200 == 0) x = '0;
      else x = W'($urandom) >> $urandom_range(15, 0);
      c = 5'd16;
      for (int b = 0; b < W; b++) if (x[b]) c = 5'(W - 1 - b);
      drive(x << c, c);
      drv_exp = {1'b0, x};
      guard = 0;
      do begin
        i_valid = ($urandom_range(3, 0) != 0);
        o_ready = ($urandom_range(3, 0) != 0);
        tick();
        guard++;
      end while (!last_acc && guard < 50);
      if (!last_acc) begin
        tests_failed++;
        $display("FAIL rt_accept: got no accept in 50 cycles, required accept");
      end
    end
    drain("rt");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rstn         = 1'b0;
    i_norm       = '0;
    i_cnt        = '0;
    i_valid      = 1'b0;
    o_ready      = 1'b0;
    drv_exp      = '0;
    last_acc     = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_classify();
    test_backpressure();
    test_reset_flush();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
